// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline.
// Combinational ALU path plus an iterative 32-step multiply/divide unit
// that owns HI/LO and holds the front of the pipeline while it runs.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ex_ctrl,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [31:0] rd1,
    input  logic [31:0] rd2,
    input  logic [31:0] immed,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    output logic [31:0] alu_result,
    output logic        zero,
    output logic [4:0]  wr_reg,
    output logic        stall,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    // R-type function codes
    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    logic        reg_dst;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic [31:0] op_b;
    logic [31:0] sum;
    logic [31:0] diff;
    logic        md_op;

    md_state_t   state_reg, state_next;
    logic [4:0]  count_reg;
    // Mult: {partial product high half, remaining multiplier bits}.
    // Div:  {partial remainder, dividend bits shifting into quotient}.
    logic [63:0] acc_reg;
    logic [31:0] opb_reg;      // multiplicand magnitude or divisor magnitude
    logic        is_div_reg;
    logic        neg_lo_reg;   // negate product / quotient at the end
    logic        neg_hi_reg;   // negate remainder at the end
    logic [31:0] hi_reg, lo_reg;

    // Start-of-operation operand preparation
    logic        op_signed;
    logic        op_is_div;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic        div_zero;
    logic [63:0] start_acc;
    logic [31:0] start_opb;
    logic        start_neg_lo, start_neg_hi;

    // One iteration step
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] acc_step;
    logic [63:0] prod_fix;
    logic [31:0] res_hi, res_lo;

    assign reg_dst = ex_ctrl[3];
    assign alu_op  = ex_ctrl[2:1];
    assign alu_src = ex_ctrl[0];

    // mult/multu/div/divu are 0x18..0x1B
    assign md_op = (alu_op == 2'b10) && (funct[5:2] == 4'b0110);

    // Operand B select; ori uses the zero-extended low halfword
    always_comb begin
        op_b = alu_src ? immed : rd2;
        if (alu_op == 2'b11) begin
            op_b = {16'b0, immed[15:0]};
        end
    end

    assign sum  = rd1 + op_b;
    assign diff = rd1 - op_b;

    // ALU result decode from ALUOp and funct
    always_comb begin
        alu_result = 32'd0;
        case (alu_op)
            2'b00: alu_result = sum;
            2'b01: alu_result = diff;
            2'b11: alu_result = rd1 | op_b;
            default: begin
                case (funct)
                    F_ADD, F_ADDU: alu_result = sum;
                    F_SUB, F_SUBU: alu_result = diff;
                    F_AND:  alu_result = rd1 & op_b;
                    F_OR:   alu_result = rd1 | op_b;
                    F_XOR:  alu_result = rd1 ^ op_b;
                    F_NOR:  alu_result = ~(rd1 | op_b);
                    F_SLT:  alu_result = ($signed(rd1) < $signed(op_b)) ? 32'd1 : 32'd0;
                    F_SLTU: alu_result = (rd1 < op_b) ? 32'd1 : 32'd0;
                    F_SLL:  alu_result = rd2 << shamt;
                    F_SRL:  alu_result = rd2 >> shamt;
                    F_SRA:  alu_result = 32'($signed(rd2) >>> shamt);
                    F_MFHI: alu_result = hi_reg;
                    F_MFLO: alu_result = lo_reg;
                    default: alu_result = 32'd0;
                endcase
            end
        endcase
    end

    assign zero   = (alu_result == 32'd0);
    assign wr_reg = reg_dst ? rd : rt;
    assign hi_out = hi_reg;
    assign lo_out = lo_reg;

    // Hold the pipeline for the whole occupancy except the final DONE cycle
    assign stall = md_op && (state_reg != MD_DONE) && !rst;

    // Operand magnitudes and result sign bookkeeping captured at start
    always_comb begin
        op_signed    = ~funct[0];
        op_is_div    = funct[1];
        a_neg        = op_signed & rd1[31];
        b_neg        = op_signed & rd2[31];
        a_mag        = a_neg ? (~rd1 + 32'd1) : rd1;
        b_mag        = b_neg ? (~rd2 + 32'd1) : rd2;
        div_zero     = op_is_div && (rd2 == 32'd0);
        start_acc    = 64'd0;
        start_opb    = 32'd0;
        start_neg_lo = 1'b0;
        start_neg_hi = 1'b0;
        if (op_is_div) begin
            // A zero divisor runs the raw dividend through unchanged so the
            // restoring loop naturally yields quotient all-ones, remainder rd1.
            start_acc    = {32'd0, div_zero ? rd1 : a_mag};
            start_opb    = b_mag;
            start_neg_lo = ~div_zero & (a_neg ^ b_neg);
            start_neg_hi = ~div_zero & a_neg;
        end else begin
            start_acc    = {32'd0, b_mag};
            start_opb    = a_mag;
            start_neg_lo = a_neg ^ b_neg;
        end
    end

    // One shift-add or restoring-subtract step, plus final sign correction
    always_comb begin
        mul_sum   = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opb_reg} : 33'd0);
        mul_next  = {mul_sum, acc_reg[31:1]};
        div_shift = {acc_reg[63:32], acc_reg[31]};
        div_diff  = {1'b0, div_shift} - {2'b0, opb_reg};
        if (div_diff[33]) begin
            div_next = {div_shift[31:0], acc_reg[30:0], 1'b0};
        end else begin
            div_next = {div_diff[31:0], acc_reg[30:0], 1'b1};
        end
        acc_step = is_div_reg ? div_next : mul_next;
        prod_fix = neg_lo_reg ? (~acc_step + 64'd1) : acc_step;
        if (is_div_reg) begin
            res_lo = neg_lo_reg ? (~acc_step[31:0] + 32'd1) : acc_step[31:0];
            res_hi = neg_hi_reg ? (~acc_step[63:32] + 32'd1) : acc_step[63:32];
        end else begin
            res_lo = prod_fix[31:0];
            res_hi = prod_fix[63:32];
        end
    end

    // MD state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= MD_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // MD next-state: DONE always returns to IDLE so the same instruction
    // still sitting in EX cannot retrigger
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            MD_IDLE: if (md_op) state_next = MD_BUSY;
            MD_BUSY: if (count_reg == 5'd31) state_next = MD_DONE;
            MD_DONE: state_next = MD_IDLE;
            default: state_next = MD_IDLE;
        endcase
    end

    // MD datapath: latch operands on start, iterate, commit HI/LO on last step
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg  <= 5'd0;
            acc_reg    <= 64'd0;
            opb_reg    <= 32'd0;
            is_div_reg <= 1'b0;
            neg_lo_reg <= 1'b0;
            neg_hi_reg <= 1'b0;
            hi_reg     <= 32'd0;
            lo_reg     <= 32'd0;
        end else begin
            case (state_reg)
                MD_IDLE: begin
                    if (md_op) begin
                        count_reg  <= 5'd0;
                        acc_reg    <= start_acc;
                        opb_reg    <= start_opb;
                        is_div_reg <= op_is_div;
                        neg_lo_reg <= start_neg_lo;
                        neg_hi_reg <= start_neg_hi;
                    end
                end
                MD_BUSY: begin
                    acc_reg   <= acc_step;
                    count_reg <= count_reg + 5'd1;
                    if (count_reg == 5'd31) begin
                        hi_reg <= res_hi;
                        lo_reg <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage. The bench plays the role of ID/EX:
// it holds each instruction in EX for as many cycles as the architecture
// says it occupies, and compares every output against a reference model
// built from plain arithmetic on each falling edge.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ex_ctrl;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] rd1, rd2, immed;
    logic [4:0]  rt, rd;
    logic [31:0] alu_result;
    logic        zero;
    logic [4:0]  wr_reg;
    logic        stall;
    logic [31:0] hi_out, lo_out;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] exp_alu, exp_hi, exp_lo;
    logic        exp_zero, exp_stall;
    logic [4:0]  exp_wr;
    bit          chk_en = 1'b0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    int          last_stall_cnt;

    ex_stage dut (
        .clk(clk), .rst(rst), .ex_ctrl(ex_ctrl), .shamt(shamt), .funct(funct),
        .rd1(rd1), .rd2(rd2), .immed(immed), .rt(rt), .rd(rd),
        .alu_result(alu_result), .zero(zero), .wr_reg(wr_reg), .stall(stall),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model's expectations
    always @(negedge clk) begin
        if (chk_en) begin
            check("alu_result", alu_result, exp_alu);
            check("zero", {31'd0, zero}, {31'd0, exp_zero});
            check("wr_reg", {27'd0, wr_reg}, {27'd0, exp_wr});
            check("stall", {31'd0, stall}, {31'd0, exp_stall});
            check("hi_out", hi_out, exp_hi);
            check("lo_out", lo_out, exp_lo);
        end
    end

    function automatic bit is_md(input logic [3:0] ctrl, input logic [5:0] fn);
        return (ctrl[2:1] == 2'b10) && (fn inside {6'h18, 6'h19, 6'h1A, 6'h1B});
    endfunction

    // Architectural ALU result
    function automatic logic [31:0] model_alu(input logic [3:0] ctrl, input logic [4:0] sh,
                                              input logic [5:0] fn, input logic [31:0] a,
                                              input logic [31:0] b_raw, input logic [31:0] imm,
                                              input logic [31:0] hi, input logic [31:0] lo);
        logic [31:0] b;
        logic signed [31:0] sa, sb, srt;
        b = ctrl[0] ? imm : b_raw;
        if (ctrl[2:1] == 2'b11) b = imm & 32'h0000FFFF;
        sa = a; sb = b; srt = b_raw;
        case (ctrl[2:1])
            2'b00: return a + b;
            2'b01: return a - b;
            2'b11: return a | b;
            default: begin
                case (fn)
                    6'h20, 6'h21: return a + b;
                    6'h22, 6'h23: return a - b;
                    6'h24: return a & b;
                    6'h25: return a | b;
                    6'h26: return a ^ b;
                    6'h27: return ~(a | b);
                    6'h2A: return (sa < sb) ? 32'd1 : 32'd0;
                    6'h2B: return (a < b) ? 32'd1 : 32'd0;
                    6'h00: return b_raw << sh;
                    6'h02: return b_raw >> sh;
                    6'h03: return 32'(srt >>> sh);
                    6'h10: return hi;
                    6'h12: return lo;
                    default: return 32'd0;
                endcase
            end
        endcase
    endfunction

    // Architectural {HI, LO} after a mult/div
    function automatic logic [63:0] md_model(input logic [5:0] fn, input logic [31:0] a,
                                             input logic [31:0] b);
        int ia, ib;
        longint la, lb, q, r;
        longint unsigned ua, ub;
        ia = a; ib = b; la = ia; lb = ib; ua = a; ub = b;
        case (fn)
            6'h18: return 64'(la * lb);
            6'h19: return 64'(ua * ub);
            6'h1A: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                q = la / lb; r = la % lb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    // Present one instruction in EX for its full occupancy.
    // rst_at >= 0 asserts reset in that cycle of the occupancy and abandons it.
    task automatic run_instr(input logic [3:0] ctrl, input logic [4:0] sh, input logic [5:0] fn,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                             input logic [4:0] trt, input logic [4:0] trd,
                             input bit use_lit, input logic [31:0] lit, input string name,
                             input int rst_at);
        bit md;
        int n;
        int st;
        logic [63:0] r;
        md = is_md(ctrl, fn);
        n  = md ? 34 : 1;
        r  = md_model(fn, a, b);
        st = 0;
        for (int k = 0; k < n; k++) begin
            if (k == rst_at) begin
                rst = 1'b1;
                ex_ctrl = 4'd0; shamt = 5'd0; funct = 6'd0;
                rd1 = 32'd0; rd2 = 32'd0; immed = 32'd0; rt = 5'd0; rd = 5'd0;
                exp_alu = 32'd0; exp_zero = 1'b1; exp_wr = 5'd0; exp_stall = 1'b0;
                exp_hi = m_hi; exp_lo = m_lo;
                @(posedge clk); #1;
                rst = 1'b0;
                m_hi = 32'd0; m_lo = 32'd0;
                exp_hi = 32'd0; exp_lo = 32'd0;
                last_stall_cnt = st;
                return;
            end
            ex_ctrl = ctrl; shamt = sh; funct = fn;
            rd1 = a; rd2 = b; immed = imm; rt = trt; rd = trd;
            if (md && k == 33) begin
                m_hi = r[63:32];
                m_lo = r[31:0];
            end
            exp_alu   = md ? 32'd0 : model_alu(ctrl, sh, fn, a, b, imm, m_hi, m_lo);
            exp_zero  = (exp_alu == 32'd0);
            exp_wr    = ctrl[3] ? trd : trt;
            exp_stall = md && (k < 33);
            exp_hi    = m_hi;
            exp_lo    = m_lo;
            #2;
            if (stall) st++;
            if (k == 0 && use_lit) check(name, alu_result, lit);
            @(posedge clk); #1;
        end
        last_stall_cnt = st;
    endtask

    function automatic logic [31:0] rnd_val();
        logic [31:0] specials [4];
        specials[0] = 32'h0; specials[1] = 32'h80000000;
        specials[2] = 32'hFFFFFFFF; specials[3] = 32'h1;
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'($urandom_range(0, 20));
            2: return 32'd0 - 32'($urandom_range(1, 20));
            default: return specials[$urandom_range(0, 3)];
        endcase
    endfunction

    localparam logic [3:0] RT = 4'b1100;   // RegDst=1, ALUOp=10, ALUSrc=0

    initial begin
        logic [5:0] ftab [16];
        logic [3:0] c;
        logic [5:0] f;
        ftab[0] = 6'h20; ftab[1] = 6'h21; ftab[2] = 6'h22; ftab[3] = 6'h23;
        ftab[4] = 6'h24; ftab[5] = 6'h25; ftab[6] = 6'h26; ftab[7] = 6'h27;
        ftab[8] = 6'h2A; ftab[9] = 6'h2B; ftab[10] = 6'h00; ftab[11] = 6'h02;
        ftab[12] = 6'h03; ftab[13] = 6'h10; ftab[14] = 6'h12; ftab[15] = 6'h3F;

        // Reset with ID/EX zeroed
        rst = 1'b1;
        ex_ctrl = 4'd0; shamt = 5'd0; funct = 6'd0;
        rd1 = 32'd0; rd2 = 32'd0; immed = 32'd0; rt = 5'd0; rd = 5'd0;
        exp_alu = 32'd0; exp_zero = 1'b1; exp_wr = 5'd0; exp_stall = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        chk_en = 1'b1;
        @(posedge clk); #1;
        check("rst_hi", hi_out, 32'd0);
        check("rst_lo", lo_out, 32'd0);
        // A mult presented while in reset must not stall or start
        ex_ctrl = RT; funct = 6'h18; rd1 = 32'd3; rd2 = 32'd4;
        #2;
        check("rst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_instr(4'd0, 5'd0, 6'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b1, 32'd0, "idle_add", -1);

        // R-type sweep
        run_instr(RT, 5'd0, 6'h20, 32'hFFFFFFFE, 32'd3, 32'd0, 5'd4, 5'd9, 1'b1, 32'h00000001, "add", -1);
        run_instr(RT, 5'd0, 6'h22, 32'hFFFFFFFE, 32'd3, 32'd0, 5'd4, 5'd9, 1'b1, 32'hFFFFFFFB, "sub", -1);
        run_instr(RT, 5'd0, 6'h2A, 32'hFFFFFFFE, 32'd3, 32'd0, 5'd4, 5'd9, 1'b1, 32'h00000001, "slt", -1);
        run_instr(RT, 5'd0, 6'h2B, 32'hFFFFFFFE, 32'd3, 32'd0, 5'd4, 5'd9, 1'b1, 32'h00000000, "sltu", -1);
        run_instr(RT, 5'd4, 6'h03, 32'd0, 32'h80000000, 32'd0, 5'd4, 5'd9, 1'b1, 32'hF8000000, "sra", -1);
        run_instr(RT, 5'd0, 6'h27, 32'd0, 32'd0, 32'd0, 5'd4, 5'd9, 1'b1, 32'hFFFFFFFF, "nor", -1);

        // Immediate and branch paths
        run_instr(4'b0111, 5'd0, 6'h00, 32'h000000F0, 32'd0, 32'hFFFF8001, 5'd7, 5'd12, 1'b1, 32'h000080F1, "ori", -1);
        run_instr(4'b0010, 5'd0, 6'h00, 32'd5, 32'd5, 32'd0, 5'd3, 5'd11, 1'b1, 32'd0, "beq", -1);

        // mult -3 * 7 then mflo
        run_instr(RT, 5'd0, 6'h18, 32'hFFFFFFFD, 32'd7, 32'd0, 5'd0, 5'd0, 1'b0, 32'd0, "mult", -1);
        check("mult_stall_cycles", 32'(last_stall_cnt), 32'd33);
        check("mult_hi", hi_out, 32'hFFFFFFFF);
        check("mult_lo", lo_out, 32'hFFFFFFEB);
        run_instr(RT, 5'd0, 6'h12, 32'd0, 32'd0, 32'd0, 5'd0, 5'd2, 1'b1, 32'hFFFFFFEB, "mflo", -1);

        // div -7 / 2, divu 7 / 0
        run_instr(RT, 5'd0, 6'h1A, 32'hFFFFFFF9, 32'd2, 32'd0, 5'd0, 5'd0, 1'b0, 32'd0, "div", -1);
        check("div_lo", lo_out, 32'hFFFFFFFD);
        check("div_hi", hi_out, 32'hFFFFFFFF);
        run_instr(RT, 5'd0, 6'h1B, 32'd7, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 32'd0, "divu0", -1);
        check("divu0_stall_cycles", 32'(last_stall_cnt), 32'd33);
        check("divu0_lo", lo_out, 32'hFFFFFFFF);
        check("divu0_hi", hi_out, 32'd7);

        // Back-to-back multu
        run_instr(RT, 5'd0, 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 5'd0, 5'd0, 1'b0, 32'd0, "multu1", -1);
        check("multu1_hi", hi_out, 32'hFFFFFFFE);
        check("multu1_lo", lo_out, 32'h00000001);
        run_instr(RT, 5'd0, 6'h19, 32'd2, 32'd3, 32'd0, 5'd0, 5'd0, 1'b0, 32'd0, "multu2", -1);
        check("multu2_hi", hi_out, 32'd0);
        check("multu2_lo", lo_out, 32'd6);

        // Reset in BUSY cycle 10 discards the operation
        run_instr(RT, 5'd0, 6'h18, 32'd123, 32'd456, 32'd0, 5'd0, 5'd0, 1'b0, 32'd0, "mult_rst", 10);
        #2;
        check("rst_mid_hi", hi_out, 32'd0);
        check("rst_mid_lo", lo_out, 32'd0);
        check("rst_mid_stall", {31'd0, stall}, 32'd0);
        run_instr(RT, 5'd0, 6'h18, 32'hFFFFFFFD, 32'd7, 32'd0, 5'd0, 5'd0, 1'b0, 32'd0, "mult_after_rst", -1);
        check("mult_after_rst_lo", lo_out, 32'hFFFFFFEB);

        // Signed overflow divide
        run_instr(RT, 5'd0, 6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'd0, 5'd0, 5'd0, 1'b0, 32'd0, "div_ovf", -1);
        check("div_ovf_lo", lo_out, 32'h80000000);
        check("div_ovf_hi", hi_out, 32'd0);

        // Randomized ALU traffic
        for (int i = 0; i < 160; i++) begin
            c = 4'($urandom);
            f = ftab[$urandom_range(0, 15)];
            if (f == 6'h3F) f = 6'($urandom);
            if (is_md(c, f)) f = 6'h20;
            run_instr(c, 5'($urandom), f, rnd_val(), rnd_val(), rnd_val(),
                      5'($urandom), 5'($urandom), 1'b0, 32'd0, "", -1);
        end

        // Randomized mult/div, each followed by mfhi and mflo
        for (int i = 0; i < 14; i++) begin
            f = 6'h18 + 6'($urandom_range(0, 3));
            run_instr(RT, 5'd0, f, rnd_val(), rnd_val(), 32'd0, 5'd0, 5'd0, 1'b0, 32'd0, "", -1);
            run_instr(RT, 5'd0, 6'h10, 32'd0, 32'd0, 32'd0, 5'd1, 5'd2, 1'b0, 32'd0, "", -1);
            run_instr(RT, 5'd0, 6'h12, 32'd0, 32'd0, 32'd0, 5'd1, 5'd3, 1'b0, 32'd0, "", -1);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage MIPS pipeline. Consumes the ID/EX pipeline register outputs and computes the ALU result and destination register for EX/MEM. Owns the HI/LO registers and an iterative 32-cycle multiply/divide unit. While a mult/div is in flight it asserts `stall`, which holds PC, IF/ID and ID/EX (their `en_reg` = ~stall).

## Interface
Parameters: none.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- ex_ctrl  in  4  from ID/EX EX field:
  - [3] RegDst
  - [2:1] ALUOp
  - [0] ALUSrc
- shamt  in  5  shift amount.
- funct  in  6  R-type function code.
- rd1  in  32  rs operand.
- rd2  in  32  rt operand.
- immed  in  32  sign-extended immediate.
- rt  in  5  rt register number.
- rd  in  5  rd register number.
- alu_result  out  32  combinational result to EX/MEM.
- zero  out  1  alu_result == 0.
- wr_reg  out  5  RegDst ? rd : rt.
- stall  out  1  pipeline hold request.
- hi_out  out  32  current HI register.
- lo_out  out  32  current LO register.

## Operation
Operand B:
- B = ALUSrc ? immed : rd2.
- When ALUOp=11, B = {16'b0, immed[15:0]}.

ALUOp decode:
- 00: add (lw/sw).
- 01: sub (beq).
- 11: OR (ori).
- 10: R-type, decoded by funct.

R-type funct map (hex):
- 20/21 add.
- 22/23 sub.
- 24 and.
- 25 or.
- 26 xor.
- 27 nor.
- 2A slt (signed): result 32'd1 or 0.
- 2B sltu: result 32'd1 or 0.
- 00 sll rt by shamt.
- 02 srl.
- 03 sra (arithmetic).
- 10 mfhi: result = HI.
- 12 mflo: result = LO.
- 18 mult, 19 multu, 1A div, 1B divu: alu_result = 0; start the MD unit.
- Any other funct: result 0.

Arithmetic rules:
- All add/sub are modulo 2^32.
- No overflow trap.

MD unit FSM, states IDLE, BUSY, DONE:
- IDLE → BUSY when ALUOp=10 and funct ∈ {18,19,1A,1B}.
  - Latch |rd1| and |rd2| for signed ops (raw values for unsigned) and the result signs.
  - Clear the 5-bit counter.
- BUSY: one shift-add (mult) or restoring-subtract (div) step per cycle.
  - On count 31: go to DONE and write HI/LO at that same edge.
- DONE → IDLE unconditionally. This prevents re-triggering on the same instruction still in ID/EX.

Multiply results:
- mult: 64-bit product, negated if the operand signs differ. HI = [63:32], LO = [31:0].
- multu: unsigned product, same split.

Divide results:
- LO = quotient, HI = remainder.
- Signed: quotient negated if signs differ; remainder takes the dividend's sign.
- 0x80000000 / 0xFFFFFFFF (signed): LO = 0x80000000, HI = 0.
- Divide by zero (any signedness): LO = 0xFFFFFFFF, HI = rd1 unchanged. Same latency, no sign correction.

stall:
- stall = mult/div decoded in EX AND state ≠ DONE.
- Forced 0 while rst.

## Timing
- ALU path, zero, wr_reg: combinational, zero latency.
- Reset values:
  - HI = 0, LO = 0, state = IDLE, counter = 0.
  - stall = 0 during rst.
  - alu_result follows inputs (ID/EX resets to 0, so add 0+0 = 0, zero = 1, wr_reg = 0).
- Mult/div cycle sequence, with cycle 0 = instruction first presented in EX:
  - Cycle 0: stall=1, state IDLE.
  - Cycles 1–32: BUSY, stall=1.
  - Edge ending cycle 32: HI/LO written.
  - Cycle 33: DONE, stall=0. ID/EX loads the next instruction at the end of cycle 33.
  - Instruction occupies EX for 34 cycles; stall high for 33.
- Back-to-back mult/div: the second one starts from IDLE in cycle 34, with identical timing.
- mfhi/mflo immediately after a mult/div reads the new HI/LO, because they are written before the mfhi/mflo reaches EX.
- HI/LO change only at the end of BUSY.
- rst mid-BUSY: at the next edge, state → IDLE and HI/LO → 0. The partial result is discarded.

## Test plan
- R-type sweep:
  - rd1=0xFFFFFFFE, rd2=3: add → 0x00000001; sub → 0xFFFFFFFB; slt → 1; sltu → 0.
  - sra of 0x80000000 by 4 → 0xF8000000.
  - nor 0,0 → 0xFFFFFFFF.
- Immediate/branch paths:
  - ALUOp=11, rd1=0x00F0, immed=0xFFFF8001 → 0x0000_80F1.
  - ALUOp=01, rd1=rd2=5 → zero=1.
  - RegDst=0 → wr_reg=rt.
- mult rd1=0xFFFFFFFD (−3), rd2=7:
  - stall high for exactly 33 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - Following mflo → 0xFFFFFFEB.
- div −7 / 2:
  - LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu 7/0 → LO=0xFFFFFFFF, HI=7, same 34-cycle occupancy.
- Back-to-back multu (0xFFFFFFFF × 0xFFFFFFFF, then 2×3):
  - First gives HI=0xFFFFFFFE, LO=1.
  - Second gives HI=0, LO=6.
  - Two separate 33-cycle stall windows with one stall-low cycle between.
- rst asserted in BUSY cycle 10:
  - Next cycle: state IDLE, HI=LO=0, stall=0.
  - A new mult after reset completes normally.
